// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters,
// with registered operands and a one-deep response buffer per requester.

package cpu_types_pkg;
    localparam int WORD_W = 32;

    typedef logic [3:0] aluop_t;

    typedef struct packed {
        logic [WORD_W-1:0] out;
        logic              of;
        logic              zf;
        logic              nf;
    } rsp_t;
endpackage

module alu_arbiter
    import cpu_types_pkg::*;
#(
    parameter logic RR_INIT = 1'b0
) (
    input  logic              CLK,
    input  logic              nRST,

    input  logic              req0_valid,
    input  aluop_t            req0_op,
    input  logic [WORD_W-1:0] req0_porta,
    input  logic [WORD_W-1:0] req0_portb,
    output logic              req0_ready,

    input  logic              req1_valid,
    input  aluop_t            req1_op,
    input  logic [WORD_W-1:0] req1_porta,
    input  logic [WORD_W-1:0] req1_portb,
    output logic              req1_ready,

    output logic              rsp0_valid,
    output logic [WORD_W-1:0] rsp0_out,
    output logic              rsp0_of,
    output logic              rsp0_zf,
    output logic              rsp0_nf,
    input  logic              rsp0_ready,

    output logic              rsp1_valid,
    output logic [WORD_W-1:0] rsp1_out,
    output logic              rsp1_of,
    output logic              rsp1_zf,
    output logic              rsp1_nf,
    input  logic              rsp1_ready,

    output aluop_t            alu_op,
    output logic [WORD_W-1:0] alu_porta,
    output logic [WORD_W-1:0] alu_portb,
    input  logic [WORD_W-1:0] alu_out,
    input  logic              alu_of,
    input  logic              alu_zf,
    input  logic              alu_nf
);

    logic [1:0]        req_valid;
    logic [1:0]        rsp_ready;
    logic [1:0]        elig;
    logic [1:0]        grant;

    logic              issue_valid;
    logic              issue_id;
    aluop_t            issue_op;
    logic [WORD_W-1:0] issue_a;
    logic [WORD_W-1:0] issue_b;

    logic [1:0]        rsp_valid;
    rsp_t              rsp_q [2];
    rsp_t              alu_res;
    logic              prio;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};
    assign alu_res   = '{out: alu_out, of: alu_of, zf: alu_zf, nf: alu_nf};

    // A requester is blocked while its op is in flight or while its
    // response slot is full and not being drained this cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        elig  = 2'b00;
        grant = 2'b00;
        for (int n = 0; n < 2; n++) begin
            elig[n] = !(issue_valid && issue_id == 1'(n)) && (!rsp_valid[n] || rsp_ready[n]);
        end
        case (req_valid & elig)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            issue_valid <= 1'b0;
            issue_id    <= 1'b0;
            issue_op    <= '0;
            issue_a     <= '0;
            issue_b     <= '0;
            prio        <= RR_INIT;
        end else if (grant != 2'b00) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            issue_valid <= 1'b1;
            issue_id    <= grant[1];
            issue_op    <= grant[1] ? req1_op    : req0_op;
            issue_a     <= grant[1] ? req1_porta : req0_porta;
            issue_b     <= grant[1] ? req1_portb : req0_portb;
            prio        <= ~grant[1];
        end else begin
            issue_valid <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rsp_valid <= 2'b00;
            // NOTE: response data is reset as well so the result outputs read 0 straight out of reset.
            rsp_q[0]  <= '0;
            rsp_q[1]  <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (issue_valid && issue_id == 1'(n)) begin
                    rsp_valid[n] <= 1'b1;
                    rsp_q[n]     <= alu_res;
                end else if (rsp_valid[n] && rsp_ready[n]) begin
                    rsp_valid[n] <= 1'b0;
                end
            end
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    assign alu_op    = issue_op;
    assign alu_porta = issue_a;
    assign alu_portb = issue_b;

    assign rsp0_valid = rsp_valid[0];
    assign rsp0_out   = rsp_q[0].out;
    assign rsp0_of    = rsp_q[0].of;
    assign rsp0_zf    = rsp_q[0].zf;
    assign rsp0_nf    = rsp_q[0].nf;

    assign rsp1_valid = rsp_valid[1];
    assign rsp1_out   = rsp_q[1].out;
    assign rsp1_of    = rsp_q[1].of;
    assign rsp1_zf    = rsp_q[1].zf;
    assign rsp1_nf    = rsp_q[1].nf;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: the bench plays the ALU and keeps a
// transaction-level model (in-flight queue with due cycles) of the arbiter.
module tb_alu_arbiter;
    import cpu_types_pkg::*;

    typedef logic [WORD_W-1:0] word_t;

    localparam aluop_t OP_SLL  = 4'h0;
    localparam aluop_t OP_SRL  = 4'h1;
    localparam aluop_t OP_ADD  = 4'h2;
    localparam aluop_t OP_SUB  = 4'h3;
    localparam aluop_t OP_AND  = 4'h4;
    localparam aluop_t OP_OR   = 4'h5;
    localparam aluop_t OP_XOR  = 4'h6;
    localparam aluop_t OP_NOR  = 4'h7;
    localparam aluop_t OP_SLT  = 4'h8;
    localparam aluop_t OP_SLTU = 4'h9;

    logic   CLK = 1'b0;
    logic   nRST = 1'b0;
    logic   req0_valid = 1'b0, req1_valid = 1'b0;
    aluop_t req0_op = '0, req1_op = '0;
    word_t  req0_porta = '0, req0_portb = '0, req1_porta = '0, req1_portb = '0;
    logic   req0_ready, req1_ready;
    logic   rsp0_valid, rsp1_valid;
    word_t  rsp0_out, rsp1_out;
    logic   rsp0_of, rsp0_zf, rsp0_nf, rsp1_of, rsp1_zf, rsp1_nf;
    logic   rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    aluop_t alu_op;
    word_t  alu_porta, alu_portb, alu_out;
    logic   alu_of, alu_zf, alu_nf;

    always #5 CLK = ~CLK;

    alu_arbiter #(.RR_INIT(1'b0)) dut (
        .CLK(CLK), .nRST(nRST),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_porta(req0_porta),
        .req0_portb(req0_portb), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_porta(req1_porta),
        .req1_portb(req1_portb), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_out(rsp0_out), .rsp0_of(rsp0_of),
        .rsp0_zf(rsp0_zf), .rsp0_nf(rsp0_nf), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_out(rsp1_out), .rsp1_of(rsp1_of),
        .rsp1_zf(rsp1_zf), .rsp1_nf(rsp1_nf), .rsp1_ready(rsp1_ready),
        .alu_op(alu_op), .alu_porta(alu_porta), .alu_portb(alu_portb),
        .alu_out(alu_out), .alu_of(alu_of), .alu_zf(alu_zf), .alu_nf(alu_nf)
    );

    // Behavioural ALU: plain arithmetic, unknown ops give 0 with zf = 1.
    function automatic rsp_t alu_ref(aluop_t op, word_t a, word_t b);
        rsp_t r;
        r = '0;
        case (op)
            OP_SLL:  r.out = a << b[4:0];
            OP_SRL:  r.out = a >> b[4:0];
            OP_ADD: begin
                r.out = a + b;
                r.of  = (a[WORD_W-1] == b[WORD_W-1]) && (r.out[WORD_W-1] != a[WORD_W-1]);
            end
            OP_SUB: begin
                r.out = a - b;
                r.of  = (a[WORD_W-1] != b[WORD_W-1]) && (r.out[WORD_W-1] != a[WORD_W-1]);
            end
            OP_AND:  r.out = a & b;
            OP_OR:   r.out = a | b;
            OP_XOR:  r.out = a ^ b;
            OP_NOR:  r.out = ~(a | b);
            OP_SLT:  r.out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: r.out = (a < b) ? 32'd1 : 32'd0;
            default: r.out = '0;
        endcase
        r.zf = (r.out == '0);
        r.nf = r.out[WORD_W-1];
        return r;
    endfunction

    rsp_t alu_res;
    assign alu_res = alu_ref(alu_op, alu_porta, alu_portb);
    assign alu_out = alu_res.out;
    assign alu_of  = alu_res.of;
    assign alu_zf  = alu_res.zf;
    assign alu_nf  = alu_res.nf;

    typedef struct {
        int   id;
        rsp_t res;
        int   due;
    } txn_t;

    int     n_cmp  = 0;
    int     n_fail = 0;
    int     cyc    = 0;
    txn_t   inflight [$];
    logic   m_rv [2];
    rsp_t   m_rd [2];
    logic   m_prio;
    logic [1:0] m_grant;
    aluop_t last_op;
    word_t  last_a, last_b;

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit in_flight(int id);
        foreach (inflight[i]) if (inflight[i].id == id) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        inflight.delete();
        for (int n = 0; n < 2; n++) begin
            m_rv[n] = 1'b0;
            m_rd[n] = '0;
        end
        m_prio  = 1'b0;
        m_grant = 2'b00;
        last_op = '0;
        last_a  = '0;
        last_b  = '0;
    endtask

    // Settle, predict this cycle's grant from the model and compare all outputs.
    task automatic settle_and_check();
        logic [1:0] want;
        bit ok0, ok1;
        #1;
        ok0 = req0_valid && !in_flight(0) && (!m_rv[0] || rsp0_ready);
        ok1 = req1_valid && !in_flight(1) && (!m_rv[1] || rsp1_ready);
        if (ok0 && ok1)  want = m_prio ? 2'b10 : 2'b01;
        else if (ok0)    want = 2'b01;
        else if (ok1)    want = 2'b10;
        else             want = 2'b00;
        m_grant = want;
        chk("req0_ready", word_t'(req0_ready), word_t'(want[0]));
        chk("req1_ready", word_t'(req1_ready), word_t'(want[1]));
        chk("rsp0_valid", word_t'(rsp0_valid), word_t'(m_rv[0]));
        chk("rsp1_valid", word_t'(rsp1_valid), word_t'(m_rv[1]));
        chk("rsp0_out", rsp0_out, m_rd[0].out);
        chk("rsp1_out", rsp1_out, m_rd[1].out);
        chk("rsp0_flags", word_t'({rsp0_of, rsp0_zf, rsp0_nf}), word_t'({m_rd[0].of, m_rd[0].zf, m_rd[0].nf}));
        chk("rsp1_flags", word_t'({rsp1_of, rsp1_zf, rsp1_nf}), word_t'({m_rd[1].of, m_rd[1].zf, m_rd[1].nf}));
        chk("alu_op", word_t'(alu_op), word_t'(last_op));
        chk("alu_porta", alu_porta, last_a);
        chk("alu_portb", alu_portb, last_b);
    endtask

    task automatic tick();
        @(posedge CLK);
        if (m_rv[0] && rsp0_ready) m_rv[0] = 1'b0;
        if (m_rv[1] && rsp1_ready) m_rv[1] = 1'b0;
        cyc++;
        for (int i = inflight.size() - 1; i >= 0; i--) begin
            if (inflight[i].due == cyc) begin
                m_rv[inflight[i].id] = 1'b1;
                m_rd[inflight[i].id] = inflight[i].res;
                inflight.delete(i);
            end
        end
        if (m_grant != 2'b00) begin
            txn_t t;
            last_op = m_grant[1] ? req1_op    : req0_op;
            last_a  = m_grant[1] ? req1_porta : req0_porta;
            last_b  = m_grant[1] ? req1_portb : req0_portb;
            t.id  = m_grant[1] ? 1 : 0;
            t.res = alu_ref(last_op, last_a, last_b);
            t.due = cyc + 1;
            inflight.push_back(t);
            m_prio = ~m_grant[1];
        end
        #1;
    endtask

    task automatic step();
        settle_and_check();
        tick();
    endtask

    task automatic idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
    endtask

    task automatic apply_reset();
        #2 nRST = 1'b0;
        #1;
        chk("rst_rsp0_valid", word_t'(rsp0_valid), '0);
        chk("rst_rsp1_valid", word_t'(rsp1_valid), '0);
        chk("rst_rsp0_out", rsp0_out, '0);
        chk("rst_rsp1_out", rsp1_out, '0);
        chk("rst_alu_op", word_t'(alu_op), '0);
        chk("rst_alu_porta", alu_porta, '0);
        chk("rst_alu_portb", alu_portb, '0);
        model_clear();
        req0_valid = 1'b1;
        req1_valid = 1'b0;
        #1 chk("rst_req0_ready", word_t'(req0_ready), 32'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        #1 chk("rst_req1_ready", word_t'(req1_ready), 32'd1);
        idle();
        @(posedge CLK);
        #2 nRST = 1'b1;
        #1;
    endtask

    function automatic word_t pick_word();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        word_t held;
        model_clear();
        apply_reset();

        // SLT -1 < 1, two-cycle latency, same requester blocked at t+1.
        req0_valid = 1'b1; req0_op = OP_SLT; req0_porta = 32'hFFFF_FFFF; req0_portb = 32'd1;
        settle_and_check();
        chk("slt_accept", word_t'(req0_ready), 32'd1);
        tick();
        settle_and_check();
        chk("slt_blocked_t1", word_t'(req0_ready), 32'd0);
        chk("slt_alu_op_t1", word_t'(alu_op), word_t'(OP_SLT));
        tick();
        req0_valid = 1'b0;
        settle_and_check();
        chk("slt_valid_t2", word_t'(rsp0_valid), 32'd1);
        chk("slt_out_t2", rsp0_out, 32'd1);
        chk("slt_zf_nf_t2", word_t'({rsp0_zf, rsp0_nf}), 32'd0);
        tick();
        step();

        // Both requesters streaming ADDs: grants alternate starting with 0.
        apply_reset();
        req0_valid = 1'b1; req1_valid = 1'b1; req0_op = OP_ADD; req1_op = OP_ADD;
        for (int i = 0; i < 8; i++) begin
            req0_porta = $urandom; req0_portb = $urandom;
            req1_porta = $urandom; req1_portb = $urandom;
            settle_and_check();
            chk("alt_grant0", word_t'(req0_ready), word_t'(i % 2 == 0));
            tick();
        end
        idle();
        step(); step(); step();

        // Signed overflow on requester 1.
        req1_valid = 1'b1; req1_op = OP_ADD; req1_porta = 32'h7FFF_FFFF; req1_portb = 32'd1;
        step();
        req1_valid = 1'b0;
        step();
        settle_and_check();
        chk("ovf_out", rsp1_out, 32'h8000_0000);
        chk("ovf_of_nf", word_t'({rsp1_of, rsp1_nf}), 32'd3);
        tick();

        // Back-pressure on rsp0: req0 stalls, req1 keeps going, rsp0 holds.
        req0_valid = 1'b1; req1_valid = 1'b1; req0_op = OP_SUB; req1_op = OP_XOR;
        rsp0_ready = 1'b0;
        held = '0;
        for (int i = 0; i < 10; i++) begin
            req1_porta = $urandom; req1_portb = $urandom;
            settle_and_check();
            if (m_rv[0]) begin
                if (held == '0) held = m_rd[0].out ^ 32'hA5A5_A5A5;
                chk("bp_req0_stalled", word_t'(req0_ready), 32'd0);
                chk("bp_rsp0_stable", rsp0_out ^ 32'hA5A5_A5A5, held);
            end
            tick();
        end
        rsp0_ready = 1'b1;
        settle_and_check();
        chk("bp_release", word_t'(req0_ready), 32'd1);
        tick();
        idle();
        step(); step(); step();

        // Reset with an op in the issue register and rsp1 pending.
        rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_op = OP_OR; req1_porta = $urandom; req1_portb = $urandom;
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op = OP_AND; req0_porta = $urandom; req0_portb = $urandom;
        step();
        req0_valid = 1'b0;
        settle_and_check();
        chk("pre_rst_rsp1_valid", word_t'(rsp1_valid), 32'd1);
        apply_reset();
        for (int i = 0; i < 4; i++) step();

        // Only req1 valid with prio = 0 after reset.
        req1_valid = 1'b1; req1_op = OP_SLTU; req1_porta = 32'd3; req1_portb = 32'd9;
        settle_and_check();
        chk("lone_req1_grant", word_t'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        step();
        req0_valid = 1'b1; req1_valid = 1'b1;
        settle_and_check();
        chk("prio_back_to_0", word_t'(req0_ready), 32'd1);
        tick();

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            req0_op    = aluop_t'($urandom_range(0, 15));
            req1_op    = aluop_t'($urandom_range(0, 15));
            req0_porta = pick_word(); req0_portb = pick_word();
            req1_porta = pick_word(); req1_portb = pick_word();
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        idle();
        for (int i = 0; i < 4; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational `alu` between two requesters, such as the execute stage and a multiply/divide sequencer, or two cores in the dual-core build.
- Arbitration is round-robin. Each requester may have one operation outstanding.
- Operands are registered before they reach the ALU.
- Each requester gets a one-deep response buffer with a valid/ready handshake.
- Fixed latency: 2 cycles from acceptance to response-valid.

## Interface
Parameters:
- RR_INIT, default 0: requester that holds priority after reset.
- Widths come from cpu_types_pkg: WORD_W = 32, aluop_t = 4 bits.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- nRST  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  request valid.
- req0_op / req1_op  in  aluop_t  requested ALU operation.
- req0_porta, req0_portb / req1_porta, req1_portb  in  WORD_W  operands.
- req0_ready / req1_ready  out  1  grant; the request is accepted when valid && ready in the same cycle.
- rsp0_valid / rsp1_valid  out  1  result available.
- rsp0_out / rsp1_out  out  WORD_W  result.
- rsp0_of, rsp0_zf, rsp0_nf / rsp1_of, rsp1_zf, rsp1_nf  out  1  flags.
- rsp0_ready / rsp1_ready  in  1  consumer takes the response.
- alu_op  out  aluop_t  to alu op.
- alu_porta, alu_portb  out  WORD_W  to alu.
- alu_out  in  WORD_W  from alu.
- alu_of, alu_zf, alu_nf  in  1  from alu.

## Operation
- Registered state:
  - issue_valid, issue_id, issue_op, issue_a, issue_b.
  - Per-requester rspN_valid and rspN data, where rspN data = out, of, zf, nf.
  - prio: 1 bit.
- The issue register drives alu_op, alu_porta and alu_portb continuously. They are unchanged while issue_valid = 0.
- Eligibility: eligN = !(issue_valid && issue_id == N) && (!rspN_valid || rspN_ready).
- Grant, combinational:
  - If both reqN_valid && eligN: grant requester `prio`.
  - If exactly one is valid and eligible: grant that one.
  - Otherwise: no grant.
  - reqN_ready = grantN. At most one grant per cycle.
  - reqN_ready does not depend on the other requester's valid only if that requester is ineligible; implementers must not form combinational loops with reqN_valid. Requesters must not make valid depend on ready.
- On a grant to N:
  - The issue register loads (1, N, reqN_op, reqN_porta, reqN_portb).
  - prio <= ~N.
  - prio is unchanged in any cycle without a grant.
- If issue_valid and no new grant: issue_valid <= 0; the operands hold.
- Writeback: if issue_valid, rsp[issue_id] <= {alu_out, alu_of, alu_zf, alu_nf} and rspN_valid <= 1. The slot is guaranteed free by the eligibility rule.
- Response pop: rspN_valid && rspN_ready clears rspN_valid, unless a writeback to N occurs on the same edge. That cannot happen, because an in-flight op makes N ineligible.
- rsp data holds its value while valid and not popped.
- The ALU flags are passed through unmodified. The ALU result for an unknown op is 0 with zf = 1; it is forwarded as-is.

## Timing
- Reset (nRST low, asynchronous): all outputs return to these values immediately.
  - issue_valid = 0, issue_op = 4'h0, issue_a = issue_b = 0.
  - alu_op = 0, alu_porta = alu_portb = 0.
  - rspN_valid = 0 and all rsp data = 0.
  - prio = RR_INIT.
  - reqN_ready follows eligibility; it is 1 when reqN_valid is high.
- Reset mid-operation: the in-flight op and any pending responses are discarded. No response is produced after reset deasserts.
- Latency for a request accepted in cycle t:
  - alu_* shows its operands in cycle t+1.
  - rspN_valid is high with its result in cycle t+2.
- Per-requester throughput: one op every 2 cycles when the consumer holds rspN_ready = 1. The same requester is ineligible in cycle t+1.
- Aggregate throughput: the ALU does useful work every cycle when both requesters alternate.
- Back-pressure: if rspN_valid && !rspN_ready, requester N is ineligible. The other requester proceeds unaffected.
- Simultaneous pop and new accept for the same N in one cycle is allowed. The response slot is freed at the same edge the issue register loads.

## Test plan
- Reset, then req0 SLT a = 0xFFFFFFFF, b = 1 at t, with rsp0_ready = 1 → alu_op = SLT at t+1; rsp0_valid at t+2 with out = 1, zf = 0, nf = 0; req0_ready = 0 at t+1.
- req0 and req1 valid every cycle with ADD, RR_INIT = 0 → grants alternate 0,1,0,1; each response arrives 2 cycles after its grant with the correct sum.
- req1 ADD 0x7FFFFFFF + 1 → rsp1_out = 0x80000000, of = 1, nf = 1.
- Hold rsp0_ready = 0 after one response while req0 and req1 stay valid → req0_ready stays 0, req1 is granted every 2 cycles, rsp0 data is stable; raising rsp0_ready re-enables req0 in the same cycle.
- Pull nRST low while one op is in the issue register and rsp1_valid = 1 → all valids are 0 immediately; after release, no response appears until a new request is accepted.
- Only req1 valid with prio = 0 → req1 granted immediately; prio becomes 0 afterwards.
